// File: rtl/spi_byte_phy.sv
// rtl/spi_byte_phy.sv - SPI mode-0 byte-level slave PHY with oversampled, synchronized inputs
module spi_byte_phy (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       cs,
    input  logic       sdi,
    output logic       sdo,
    input  logic [7:0] idata,
    input  logic       tx_en,
    output logic [7:0] odata,
    output logic       rx_valid,
    output logic       tx_done,
    output logic       frame_err,
    output logic       cs_active
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  sck_sync, cs_sync;
    logic [1:0]  sdi_sync;
    logic [1:0]  fill;
    logic        cs_ready;
    logic [2:0]  bit_cnt, cnt_inc, cnt_after;
    logic [7:0]  rx_shift, tx_shift, tx_load;
    logic        tx_armed, done_armed, byte_done;
    logic        sck_rise, sck_fall, cs_rise, cs_fall, sdi_bit;

    // Index 0/1 are the synchronizer, index 2 is the edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync <= 3'b000;
            cs_sync  <= 3'b111;
            sdi_sync <= 2'b00;
            fill     <= 2'b00;
            cs_ready <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[1:0], sck};
            cs_sync  <= {cs_sync[1:0], cs};
            sdi_sync <= {sdi_sync[0], sdi};
            fill     <= {fill[0], 1'b1};
            // A frame may only start once cs has really been seen high after reset.
            if (fill[1] && cs_sync[1])
                cs_ready <= 1'b1;
        end
    end

    assign sck_rise  = sck_sync[1] & ~sck_sync[2];
    assign sck_fall  = ~sck_sync[1] & sck_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign cs_fall   = cs_ready & ~cs_sync[1] & cs_sync[2];
    assign sdi_bit   = sdi_sync[1];
    assign cnt_inc   = bit_cnt + 3'd1;
    assign cnt_after = sck_rise ? cnt_inc : bit_cnt;
    assign tx_load   = tx_en ? idata : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cs_active = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall)
                    state_nxt = ACTIVE;
            end
            ACTIVE: begin
                cs_active = 1'b1;
                if (cs_rise)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sdo = cs_active & tx_shift[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= 3'd0;
            rx_shift   <= 8'h00;
            tx_shift   <= 8'h00;
            tx_armed   <= 1'b0;
            done_armed <= 1'b0;
            byte_done  <= 1'b0;
            odata      <= 8'h00;
            rx_valid   <= 1'b0;
            tx_done    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            rx_valid  <= 1'b0;
            tx_done   <= 1'b0;
            frame_err <= 1'b0;
            // Publishing one cycle after the shift keeps odata and both pulses aligned.
            if (byte_done) begin
                odata    <= rx_shift;
                rx_valid <= 1'b1;
                tx_done  <= done_armed;
            end
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt  <= 3'd0;
                        tx_shift <= tx_load;
                        tx_armed <= tx_en;
                    end
                end
                ACTIVE: begin
                    if (sck_rise) begin
                        rx_shift <= {rx_shift[6:0], sdi_bit};
                        bit_cnt  <= cnt_inc;
                        if (bit_cnt == 3'd7) begin
                            byte_done  <= 1'b1;
                            done_armed <= tx_armed;
                        end
                    end
                    if (sck_fall) begin
                        if (bit_cnt == 3'd0) begin
                            tx_shift <= tx_load;
                            tx_armed <= tx_en;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                    if (cs_rise) begin
                        bit_cnt <= 3'd0;
                        if (cnt_after != 3'd0)
                            frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_phy.sv
// tb/tb_spi_byte_phy.sv - randomized and directed self-checking bench for spi_byte_phy
module tb_spi_byte_phy;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       cs = 1'b1;
    logic       sdi = 1'b0;
    logic       tx_en = 1'b0;
    logic [7:0] idata = 8'h00;
    logic       sdo;
    logic [7:0] odata;
    logic       rx_valid, tx_done, frame_err, cs_active;

    spi_byte_phy dut (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs), .sdi(sdi), .sdo(sdo),
        .idata(idata), .tx_en(tx_en), .odata(odata), .rx_valid(rx_valid),
        .tx_done(tx_done), .frame_err(frame_err), .cs_active(cs_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise8_cyc = 0;
    logic [7:0] exp_rx[$];
    bit         exp_txd[$];
    int         exp_ferr = 0;
    logic [7:0] exp_odata = 8'h00;
    logic       prev_rv = 0, prev_td = 0, prev_fe = 0;
    logic [7:0] mb;
    bit         mt;

    logic [7:0] fb[8], fdat[8], fmiso[8];
    bit         fen[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    // Every cycle: each completed byte must surface 3 clk edges after its 8th sck capture.
    always @(negedge clk) begin
        if (rst) begin
            prev_rv = 0; prev_td = 0; prev_fe = 0;
        end else begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    chk("unexpected_rx_valid", 1, 0);
                end else begin
                    mb = exp_rx.pop_front();
                    mt = exp_txd.pop_front();
                    chk("odata", odata, mb);
                    chk("tx_done", tx_done, mt);
                    chk("rx_latency", cyc - rise8_cyc, 4);
                    exp_odata = mb;
                end
            end else begin
                chk("odata_hold", odata, exp_odata);
                chk("tx_done_alone", tx_done, 0);
            end
            if (frame_err) begin
                chk("frame_err_expected", exp_ferr > 0, 1);
                if (exp_ferr > 0) exp_ferr--;
            end
            chk("pulse_repeat", {rx_valid & prev_rv, tx_done & prev_td, frame_err & prev_fe}, 0);
            prev_rv = rx_valid; prev_td = tx_done; prev_fe = frame_err;
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic raw_bits(input logic [7:0] v, input int n, input int half);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = v[i];
            wait_n(half);
            sck = 1'b1;
            wait_n(half);
            sck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int half, input bit cs_at_8th,
                             input bit next_en, input logic [7:0] next_data, input bit cur_en,
                             output logic [7:0] miso);
        for (int i = 7; i >= 0; i--) begin
            sdi = b[i];
            wait_n(half);
            miso[i] = sdo;
            sck = 1'b1;
            if (i == 0) begin
                rise8_cyc = cyc;
                exp_rx.push_back(b);
                exp_txd.push_back(cur_en);
                if (cs_at_8th) cs = 1'b1;
            end
            wait_n(half);
            sck = 1'b0;
            if (i == 7) begin
                tx_en = next_en;
                idata = next_data;
            end
        end
    endtask

    task automatic run_frame(input int nb, input int half, input int gap, input bit cs_8th);
        logic [7:0] m;
        tx_en = fen[0];
        idata = fdat[0];
        wait_n(2);
        cs = 1'b0;
        wait_n(6);
        chk("cs_active_on", cs_active, 1);
        for (int k = 0; k < nb; k++) begin
            send_byte(fb[k], half, cs_8th && (k == nb - 1),
                      (k + 1 < nb) ? fen[k + 1] : 1'b0,
                      (k + 1 < nb) ? fdat[k + 1] : 8'h00, fen[k], m);
            fmiso[k] = m;
            if (half >= 3) chk("miso", m, fen[k] ? fdat[k] : 8'h00);
            wait_n(gap);
        end
        if (!cs_8th) begin
            wait_n(2);
            cs = 1'b1;
        end
        wait_n(8);
        chk("cs_active_off", cs_active, 0);
        tx_en = 1'b0;
    endtask

    task automatic set_byte(input int k, input logic [7:0] b, input bit en, input logic [7:0] d);
        fb[k] = b; fen[k] = en; fdat[k] = d;
    endtask

    initial begin
        wait_n(3);
        chk("rst_odata", odata, 8'h00);
        chk("rst_pulses", {rx_valid, tx_done, frame_err}, 3'b000);
        chk("rst_cs_active", cs_active, 0);
        chk("rst_sdo", sdo, 0);
        rst = 1'b0;
        wait_n(6);
        chk("idle_after_release", {cs_active, rx_valid, frame_err}, 3'b000);

        // Single byte, no transmit
        set_byte(0, 8'hF0, 1'b0, 8'h00);
        run_frame(1, 4, 0, 1'b0);
        chk("req030_odata", odata, 8'hF0);
        chk("req030_sdo_zero", fmiso[0], 8'h00);

        // Transmit enabled during byte 1, data appears on byte 2
        set_byte(0, 8'hF1, 1'b0, 8'h00);
        set_byte(1, 8'h00, 1'b1, 8'hA5);
        run_frame(2, 4, 2, 1'b0);
        chk("req031_miso_b2", fmiso[1], 8'hA5);
        chk("req031_odata", odata, 8'h00);

        // cs rises together with the 8th sck edge
        set_byte(0, 8'hC3, 1'b0, 8'h00);
        run_frame(1, 4, 0, 1'b1);
        chk("req033_odata", odata, 8'hC3);

        // Partial byte then a good byte
        cs = 1'b0;
        wait_n(6);
        raw_bits(8'b0001_0110, 5, 4);
        wait_n(4);
        exp_ferr++;
        cs = 1'b1;
        wait_n(8);
        chk("req032_odata_kept", odata, 8'hC3);
        chk("req032_frame_err_seen", exp_ferr, 0);
        set_byte(0, 8'h7D, 1'b0, 8'h00);
        run_frame(1, 4, 0, 1'b0);
        chk("req032_next_byte", odata, 8'h7D);

        // Reset mid-frame with sdo driven high
        tx_en = 1'b1;
        idata = 8'hFF;
        wait_n(2);
        cs = 1'b0;
        wait_n(6);
        raw_bits(8'hA0, 4, 4);
        chk("pre_rst_sdo", sdo, 1);
        #2 rst = 1'b1;
        #1;
        chk("req034_odata", odata, 8'h00);
        chk("req034_flags", {rx_valid, tx_done, frame_err, cs_active, sdo}, 5'b00000);
        exp_odata = 8'h00;
        tx_en = 1'b0;
        wait_n(3);
        rst = 1'b0;
        wait_n(6);
        // cs still low from before reset: this byte must be ignored
        raw_bits(8'h55, 8, 4);
        wait_n(8);
        chk("req029_no_active", cs_active, 0);
        cs = 1'b1;
        wait_n(8);
        set_byte(0, 8'hB0, 1'b0, 8'h00);
        run_frame(1, 4, 0, 1'b0);
        chk("req034_odata_b0", odata, 8'hB0);

        // 100 random bytes at exactly 4x oversampling
        for (int sent = 0; sent < 100; ) begin
            int nb;
            nb = $urandom_range(1, 4);
            if (sent + nb > 100) nb = 100 - sent;
            for (int k = 0; k < nb; k++) set_byte(k, 8'($urandom), 1'b0, 8'h00);
            run_frame(nb, 2, $urandom_range(0, 3), 1'b0);
            sent += nb;
        end

        // Random frames with random transmit data at slower sck
        for (int f = 0; f < 12; f++) begin
            int nb;
            nb = $urandom_range(1, 5);
            for (int k = 0; k < nb; k++)
                set_byte(k, 8'($urandom), 1'($urandom), 8'($urandom));
            run_frame(nb, $urandom_range(3, 6), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        wait_n(10);
        chk("rx_queue_empty", exp_rx.size(), 0);
        chk("ferr_pending", exp_ferr, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_byte_phy.md
SPI_BYTE_PHY -- requirements
Module: spi_byte_phy

Interface
REQ-001 clk  input  1  system clock; all logic on its rising edge; min 4x sck frequency (50 MHz clk -> sck <= 12.5 MHz).
REQ-002 rst  input  1  asynchronous, active-high reset; asserted forces reset state immediately, released synchronously to clk.
REQ-003 sck  input  1  SPI serial clock from MCU, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-004 cs  input  1  SPI chip select, active-low, asynchronous.
REQ-005 sdi  input  1  SPI serial data from MCU, MSB first.
REQ-006 sdo  output  1  SPI serial data to MCU, MSB first.
REQ-007 idata  input  8  byte to transmit, sampled at load points.
REQ-008 tx_en  input  1  transmit enable from command decoder; sampled at load points.
REQ-009 odata  output  8  last complete received byte; held until next complete byte.
REQ-010 rx_valid  output  1  one-clk pulse: odata updated this cycle.
REQ-011 tx_done  output  1  one-clk pulse: a byte loaded with tx_en=1 has been fully shifted out.
REQ-012 frame_err  output  1  one-clk pulse: cs deasserted with partial byte (1..7 bits) received.
REQ-013 cs_active  output  1  high while the frame state machine is in ACTIVE.

Function
REQ-014 sck, cs, sdi each pass through a 2-flop synchronizer; sck and cs get a third history flop for edge detection; all three share identical delay.
REQ-015 FSM states: IDLE, ACTIVE; IDLE->ACTIVE on synchronized cs falling edge; ACTIVE->IDLE on synchronized cs rising edge.
REQ-016 On IDLE->ACTIVE: bit_cnt=0; tx shift register loaded with idata if tx_en=1, else 8'h00; tx_armed=tx_en.
REQ-017 In ACTIVE, on each synchronized sck rising edge: rx shift register shifts left, LSB = synchronized sdi; bit_cnt increments mod 8.
REQ-018 On the sck rising edge that brings bit_cnt from 7 to 0: odata = completed byte and rx_valid pulses in the following clk cycle; tx_done pulses in the same cycle if tx_armed=1.
REQ-019 rx_valid latency: asserted exactly 3 clk edges after the clk edge at which sck is first sampled high by the first synchronizer flop.
REQ-020 In ACTIVE, on each synchronized sck falling edge: if bit_cnt=0 (byte boundary) reload tx shift register per REQ-016 rule (idata/tx_en sampled that cycle), else shift tx register left, LSB filled with 0.
REQ-021 sdo = tx shift register bit 7 while ACTIVE, else 0.
REQ-022 No sck edges act in IDLE; rx/tx shift registers and bit_cnt hold.
REQ-023 cs rising detected with bit_cnt != 0: partial byte discarded, odata unchanged, no rx_valid/tx_done, frame_err pulses one cycle, bit_cnt cleared.
REQ-024 cs rising detected in the same cycle as the 8th sck rising edge: byte completes normally (rx_valid, tx_done if armed), no frame_err, FSM to IDLE.
REQ-025 cs falling and sck rising detected in the same cycle: FSM enters ACTIVE with bit_cnt=0; that sck edge is ignored.
REQ-026 rx_valid, tx_done, frame_err never high in two consecutive cycles.

Reset
REQ-027 While rst=1: odata=8'h00, rx_valid=0, tx_done=0, frame_err=0, cs_active=0, sdo=0, FSM=IDLE, bit_cnt=0, shift registers=0, tx_armed=0.
REQ-028 Synchronizer flops reset to idle bus levels: sck=0, cs=1, sdi=0; no spurious edge detected on reset release.
REQ-029 rst asserted mid-frame aborts the frame without frame_err; after release a cs falling edge is required before any byte is accepted.

Verification
REQ-030 cs low, MCU sends 8'hF0, tx_en=0 -> one rx_valid pulse, odata=8'hF0, sdo stays 0, no tx_done.
REQ-031 Frame of two bytes 8'hF1 then 8'h00, tx_en raised with idata=8'hA5 before 8th sck falling edge of byte 1 -> odata=8'hF1 then 8'h00, MCU samples 8'hA5 on byte 2, one tx_done at end of byte 2.
REQ-032 cs low, 5 sck pulses with 8'b10110 pattern, cs high -> frame_err pulse, odata keeps previous value, no rx_valid; next full byte 8'h7D received correctly.
REQ-033 cs rises in same clk as 8th synchronized sck rising edge, byte 8'hC3 -> rx_valid, odata=8'hC3, no frame_err.
REQ-034 rst pulsed after 4 bits of byte -> all outputs 0 immediately; subsequent frame 8'hB0 received with odata=8'hB0.
REQ-035 Latency check at clk=4x sck: rx_valid rises exactly 3 clk edges after first-flop capture of 8th sck high, measured over 100 random bytes with odata matching sent data.
